// File: rtl/ibr128_ctr_sequencer_if.sv
// Bus bundle between the CTR sequencer, the pipelined CTR adder and the
// cipher core. The master modport is the sequencer's view; the slave modport
// is the view of the surrounding logic.
// Optional feature macro: IBR128_CTR_ABORT_EN adds the Abort input.
interface ibr128_ctr_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             Start;
    logic [127:0]     Iv;
    logic [CNT_W-1:0] NumBlocks;
    logic             Busy;
    logic             Done;
    logic             Add_Enable;
    logic [127:0]     Add_A;
    logic [127:0]     Add_B;
    logic [127:0]     Add_S;
    logic             Ctr_Valid;
    logic             Ctr_Ready;
    logic [127:0]     Ctr_Data;
    logic             Ctr_Last;
`ifdef IBR128_CTR_ABORT_EN
    logic             Abort;
`endif

    modport master (
        input  Start, Iv, NumBlocks, Add_S, Ctr_Ready,
`ifdef IBR128_CTR_ABORT_EN
        input  Abort,
`endif
        output Busy, Done, Add_Enable, Add_A, Add_B, Ctr_Valid, Ctr_Data, Ctr_Last
    );

    modport slave (
        output Start, Iv, NumBlocks, Add_S, Ctr_Ready,
`ifdef IBR128_CTR_ABORT_EN
        output Abort,
`endif
        input  Busy, Done, Add_Enable, Add_A, Add_B, Ctr_Valid, Ctr_Data, Ctr_Last
    );
endinterface

// File: rtl/ibr128_ctr_sequencer.sv
// CTR-mode counter-block generator for IBR128. Feeds the 128-bit pipelined
// CTR adder one addition at a time (A = IV, B = block index), holds the
// operands for ADD_LAT enabled cycles, captures the sum and offers it to the
// cipher core over a valid/ready handshake.
// Optional feature macro: IBR128_CTR_ABORT_EN (adds the Abort input).
module ibr128_ctr_sequencer #(
    parameter int ADD_LAT = 8,
    parameter int CNT_W   = 32
) (
    input  logic Clk,
    input  logic Rst,
    ibr128_ctr_sequencer_if.master bus
);
    localparam int LAT_W = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ADD, CAP, OUT} state_t;

    state_t           state, state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] nblk;
    logic             abort;
    logic             start_ok;
    logic             hs;
    logic             is_last;
    logic             lat_done;

`ifdef IBR128_CTR_ABORT_EN
    assign abort = bus.Abort;
`else
    assign abort = 1'b0;
`endif

    // Abort beats a simultaneous Start; Start is only looked at in IDLE.
    assign start_ok = bus.Start && !abort;
    assign hs       = bus.Ctr_Valid && bus.Ctr_Ready;
    assign is_last  = (idx == nblk - 1'b1);
    assign lat_done = (lat_cnt == LAT_W'(ADD_LAT - 1));

    assign bus.Busy       = (state != IDLE);
    assign bus.Add_Enable = (state == ADD);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok && bus.NumBlocks != '0) state_nxt = ADD;
            ADD:     if (lat_done) state_nxt = CAP;
            CAP:     state_nxt = OUT;
            OUT:     if (hs) state_nxt = is_last ? IDLE : ADD;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Datapath: operand latching, latency count, capture and handshake.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bus.Done      <= 1'b0;
            bus.Add_A     <= '0;
            bus.Add_B     <= '0;
            bus.Ctr_Data  <= '0;
            bus.Ctr_Valid <= 1'b0;
            bus.Ctr_Last  <= 1'b0;
            lat_cnt       <= '0;
            idx           <= '0;
            nblk          <= '0;
        end else begin
            bus.Done <= 1'b0;
            if (abort && state != IDLE) begin
                // Drop the pending block; operands and last data stay visible.
                bus.Ctr_Valid <= 1'b0;
                bus.Ctr_Last  <= 1'b0;
                lat_cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            if (bus.NumBlocks != '0) begin
                                bus.Add_A <= bus.Iv;
                                bus.Add_B <= '0;
                                idx       <= '0;
                                nblk      <= bus.NumBlocks;
                                lat_cnt   <= '0;
                            end else begin
                                bus.Done <= 1'b1;
                            end
                        end
                    end
                    ADD: lat_cnt <= lat_done ? '0 : lat_cnt + 1'b1;
                    CAP: begin
                        bus.Ctr_Data  <= bus.Add_S;
                        bus.Ctr_Valid <= 1'b1;
                        bus.Ctr_Last  <= is_last;
                    end
                    OUT: begin
                        if (hs) begin
                            bus.Ctr_Valid <= 1'b0;
                            bus.Ctr_Last  <= 1'b0;
                            if (is_last) begin
                                bus.Done <= 1'b1;
                            end else begin
                                idx       <= idx + 1'b1;
                                bus.Add_B <= {{(128-CNT_W){1'b0}}, idx + 1'b1};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ibr128_ctr_sequencer.sv
// Self-checking bench for ibr128_ctr_sequencer. Contains a behavioural model
// of the carry-skewed adder (sum only valid after ADD_LAT enabled cycles with
// stable operands) and checks every block against IV + index arithmetic and
// the 10-cycle start/handshake-to-valid latency.
// Optional feature macro: IBR128_CTR_ABORT_EN (exercises Abort too).
module tb_ibr128_ctr_sequencer;
    localparam int ADD_LAT = 8;
    localparam int CNT_W   = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    ibr128_ctr_sequencer_if #(.CNT_W(CNT_W)) bus ();

    ibr128_ctr_sequencer #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Adder model: result appears only once the same operands have been seen
    // on ADD_LAT enabled edges; otherwise the output is garbage.
    logic [127:0] a_lat  = '0;
    logic [127:0] b_lat  = '0;
    logic [127:0] junk   = '0;
    int unsigned  en_cnt = 0;
    always @(posedge clk) begin
        junk <= {$urandom, $urandom, $urandom, $urandom};
        if (bus.Add_Enable) begin
            if (bus.Add_A == a_lat && bus.Add_B == b_lat) en_cnt <= en_cnt + 1;
            else                                          en_cnt <= 1;
            a_lat <= bus.Add_A;
            b_lat <= bus.Add_B;
        end
    end
    assign bus.Add_S = (en_cnt >= ADD_LAT && bus.Add_A == a_lat && bus.Add_B == b_lat)
                       ? a_lat + b_lat : junk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1(tag, bus.Busy | bus.Done | bus.Add_Enable | bus.Ctr_Valid | bus.Ctr_Last, 1'b0);
        chk128(tag, bus.Add_A | bus.Add_B | bus.Ctr_Data, 128'd0);
    endtask

    // One complete run: start, then for each block check the ADD/CAP window,
    // the offered block, an optional Ready stall and the handshake aftermath.
    task automatic run_seq(input logic [127:0] iv, input int n, input int stall_blk,
                           input int stall_len);
        bus.Iv        = iv;
        bus.NumBlocks = CNT_W'(n);
        bus.Start     = 1'b1;
        bus.Ctr_Ready = 1'b1;
        tick();
        bus.Start = 1'b0;
        if (n == 0) begin
            chk1("zero_done", bus.Done, 1'b1);
            chk1("zero_busy", bus.Busy, 1'b0);
            chk1("zero_valid", bus.Ctr_Valid, 1'b0);
            tick();
            chk1("zero_done_pulse", bus.Done, 1'b0);
            chk1("zero_busy2", bus.Busy, 1'b0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            bus.Ctr_Ready = (i == stall_blk && stall_len > 0) ? 1'b0 : 1'b1;
            for (int c = 1; c <= 9; c++) begin
                chk1("lat_valid", bus.Ctr_Valid, 1'b0);
                chk1("lat_enable", bus.Add_Enable, (c <= ADD_LAT));
                chk1("lat_busy", bus.Busy, 1'b1);
                if (c == 2) begin
                    chk128("add_a", bus.Add_A, iv);
                    chk128("add_b", bus.Add_B, 128'(i));
                    chk1("lat_done", bus.Done, 1'b0);
                end
                // Start with fresh operands while busy must be ignored.
                if (c == 3) begin
                    bus.Start     = 1'b1;
                    bus.Iv        = {$urandom, $urandom, $urandom, $urandom};
                    bus.NumBlocks = CNT_W'($urandom_range(0, 9));
                end
                if (c == 4) bus.Start = 1'b0;
                tick();
            end
            chk1("blk_valid", bus.Ctr_Valid, 1'b1);
            chk128("blk_data", bus.Ctr_Data, iv + 128'(i));
            chk1("blk_last", bus.Ctr_Last, (i == n - 1));
            if (i == stall_blk) begin
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk1("stall_valid", bus.Ctr_Valid, 1'b1);
                    chk128("stall_data", bus.Ctr_Data, iv + 128'(i));
                    chk1("stall_last", bus.Ctr_Last, (i == n - 1));
                    chk1("stall_enable", bus.Add_Enable, 1'b0);
                end
            end
            bus.Ctr_Ready = 1'b1;
            tick();
            chk1("hs_valid", bus.Ctr_Valid, 1'b0);
            chk1("hs_last", bus.Ctr_Last, 1'b0);
            if (i == n - 1) begin
                chk1("end_done", bus.Done, 1'b1);
                chk1("end_busy", bus.Busy, 1'b0);
                tick();
                chk1("end_done_pulse", bus.Done, 1'b0);
            end else begin
                chk1("mid_done", bus.Done, 1'b0);
            end
        end
    endtask

    logic [127:0] riv;
    int           rn, rsb, rsl;

    initial begin
        rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.Iv        = '0;
        bus.NumBlocks = '0;
        bus.Ctr_Ready = 1'b1;
`ifdef IBR128_CTR_ABORT_EN
        bus.Abort     = 1'b0;
`endif
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Directed cases.
        run_seq(128'd0, 1, -1, 0);
        run_seq(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 3, -1, 0);
        run_seq({128{1'b1}}, 2, -1, 0);
        run_seq({$urandom, $urandom, $urandom, $urandom}, 4, 1, 5);
        run_seq(128'd77, 0, -1, 0);
        tick();

        // Reset in the fifth ADD cycle drops everything, no Done.
        bus.Iv = {$urandom, $urandom, $urandom, $urandom};
        bus.NumBlocks = CNT_W'(3);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_mid_add");
        tick();
        chk1("rst_no_done", bus.Done, 1'b0);
        run_seq(128'd5, 1, -1, 0);

`ifdef IBR128_CTR_ABORT_EN
        // Abort mid-ADD: back to IDLE, operands kept, no Done.
        riv = {$urandom, $urandom, $urandom, $urandom};
        bus.Iv = riv;
        bus.NumBlocks = CNT_W'(3);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (4) tick();
        bus.Abort = 1'b1;
        tick();
        bus.Abort = 1'b0;
        chk1("abort_busy", bus.Busy, 1'b0);
        chk1("abort_enable", bus.Add_Enable, 1'b0);
        chk1("abort_valid", bus.Ctr_Valid, 1'b0);
        chk1("abort_done", bus.Done, 1'b0);
        chk128("abort_add_a", bus.Add_A, riv);
        chk128("abort_add_b", bus.Add_B, 128'd0);
        tick();
        chk1("abort_no_done", bus.Done, 1'b0);
        run_seq(128'd5, 1, -1, 0);

        // Abort in OUT with a block pending.
        bus.Iv = riv;
        bus.NumBlocks = CNT_W'(2);
        bus.Ctr_Ready = 1'b0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (9) tick();
        chk1("abort_out_pre", bus.Ctr_Valid, 1'b1);
        bus.Abort = 1'b1;
        tick();
        bus.Abort = 1'b0;
        bus.Ctr_Ready = 1'b1;
        chk1("abort_out_valid", bus.Ctr_Valid, 1'b0);
        chk1("abort_out_busy", bus.Busy, 1'b0);
        chk1("abort_out_done", bus.Done, 1'b0);
        chk128("abort_out_data", bus.Ctr_Data, riv);

        // Abort with Start in IDLE: Start is lost.
        bus.Abort = 1'b1;
        bus.NumBlocks = CNT_W'(1);
        bus.Start = 1'b1;
        tick();
        bus.Abort = 1'b0;
        bus.Start = 1'b0;
        chk1("abort_start_busy", bus.Busy, 1'b0);
        chk1("abort_start_done", bus.Done, 1'b0);
        tick();
`endif

        // Randomised runs, alternating random IVs with near-wrap IVs.
        for (int r = 0; r < 6; r++) begin
            riv = {$urandom, $urandom, $urandom, $urandom};
            if (r % 2 == 1) riv = ~128'($urandom_range(0, 3));
            rn  = int'($urandom_range(1, 4));
            rsb = int'($urandom_range(0, rn - 1));
            rsl = int'($urandom_range(0, 5));
            run_seq(riv, rn, rsb, rsl);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ibr128_ctr_sequencer.md
Name: ibr128_ctr_sequencer

Overview:
CTR-mode counter-block generator for IBR128. It sits directly upstream of the 128-bit pipelined CTR adder: drives the adder's A, B and Enable inputs, captures its sum S, and hands finished counter blocks (IV + i) to the cipher core over a valid/ready handshake.
The adder is a carry-skewed 16-bit-slice pipeline. Its operands must be held stable for ADD_LAT enabled cycles before S is correct, so the sequencer serialises additions.

Parameters:
ADD_LAT, 8, number of enabled adder cycles until S is settled (one per 16-bit slice)
CNT_W, 32, width of the block count and block index

Ports:
Clk  in  1  clock; single clock domain
Rst  in  1  reset; one clock, reset is synchronous and active-high
Start  in  1  one-cycle request; sampled only in IDLE
Iv  in  128  initial counter value; latched on accepted Start
NumBlocks  in  CNT_W  number of counter blocks to emit; latched on accepted Start
Busy  out  1  high whenever state != IDLE
Done  out  1  one-cycle pulse after the final block handshake, or for NumBlocks=0
Add_Enable  out  1  to adder Enable
Add_A  out  128  to adder A; holds latched Iv
Add_B  out  128  to adder B; current index, zero-extended
Add_S  in  128  from adder S
Ctr_Valid  out  1  counter block available
Ctr_Ready  in  1  downstream accepts the block
Ctr_Data  out  128  counter block IV + index, mod 2^128
Ctr_Last  out  1  qualifies the final block; valid only with Ctr_Valid

Behaviour:
- Reset: state IDLE. Busy, Done, Add_Enable, Ctr_Valid and Ctr_Last are 0. Add_A, Add_B and Ctr_Data are 0. Index counter and ADD_LAT counter are 0.
- States: IDLE, ADD, CAP, OUT.
- IDLE:
  - Start with NumBlocks != 0: latch Iv into Add_A, load Add_B=0, load remaining count, go to ADD.
  - Start with NumBlocks == 0: Done pulses the next cycle, state stays IDLE.
- ADD: Add_Enable=1 for exactly ADD_LAT consecutive cycles. Add_A and Add_B do not change during ADD. Then go to CAP.
- CAP: Add_Enable=0. Register Add_S into Ctr_Data, set Ctr_Valid=1, set Ctr_Last=(index == NumBlocks-1), go to OUT.
- OUT: hold Ctr_Data, Ctr_Valid and Ctr_Last stable while Ctr_Ready=0. On Ctr_Valid and Ctr_Ready in the same cycle, deassert Ctr_Valid and Ctr_Last next cycle, then:
  - if last: Done=1 for one cycle, go to IDLE;
  - otherwise: increment index, update Add_B, go to ADD.
- Latency:
  - Start accepted at cycle 0 -> ADD in cycles 1..8 -> CAP in cycle 9 -> Ctr_Valid high from cycle 10.
  - Handshake at cycle h -> next Ctr_Valid at h+10.
  - Throughput: one block per 10 cycles with Ctr_Ready held high.
- Arithmetic: Ctr_Data = (Iv + index) mod 2^128; carry out of bit 127 is discarded. Index is less than 2^CNT_W and never overflows.
- Stale adder stage contents from a previous addition are irrelevant, since all ADD_LAT stages are recomputed.
- Start while Busy: ignored. Iv and NumBlocks changes while Busy: ignored.
- Rst at any state, including mid-ADD or in OUT with Ctr_Valid high: next cycle all outputs at reset values, no Done pulse, the pending block is dropped.

Optional Feature:
Macro IBR128_CTR_ABORT_EN.
- Defined: adds input Abort (1 bit, highest priority after Rst). Abort in any non-IDLE state forces IDLE next cycle; Ctr_Valid, Ctr_Last and Add_Enable drop to 0; Done is not pulsed; Ctr_Data, Add_A and Add_B keep their values. Abort in IDLE has no effect, and Abort wins over a simultaneous Start.
- Not defined: no Abort port; the sequence runs to completion or Rst.

Test Plan:
- Iv=0, NumBlocks=1, Ctr_Ready=1 -> Ctr_Valid at cycle 10 with Ctr_Data=0 and Ctr_Last=1; Done pulse at cycle 11; Busy low from cycle 11.
- Iv=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, NumBlocks=3, Ctr_Ready=1 -> Ctr_Data sequence ...FFFE, ...FFFF, 0x0000_0000_0000_0001_0000_0000_0000_0000 at cycles 10, 20, 30; Ctr_Last only on the third.
- Iv=all ones, NumBlocks=2 -> blocks all-ones then 0 (wrap-around, carry discarded), Done after the second handshake.
- NumBlocks=4, Ctr_Ready low for 5 cycles on block 2 -> Ctr_Data, Ctr_Valid and Ctr_Last stable throughout; Add_Enable stays 0 until the handshake; block 3 valid 10 cycles after the handshake.
- NumBlocks=0 Start -> Done pulse at cycle 1, no Ctr_Valid, Busy stays 0; a second Start during Busy on another run is ignored (block count unchanged).
- Rst asserted in cycle 5 of ADD -> all outputs at reset values next cycle, no Done. A new Start with Iv=5, NumBlocks=1 then yields Ctr_Data=5 at 10-cycle latency. With IBR128_CTR_ABORT_EN defined, repeat using Abort instead of Rst and check the same recovery plus no Done pulse.
